// File: rtl/arduino_cmd_tx.sv
// Command link from the FPGA to the Arduino: a small FIFO of 8-bit frames, each sent on one pin as async 8N1.
// Define ARDUINO_TX_PARITY_EN to add an even-parity bit after the data bits, which makes the line 8E1.
module arduino_cmd_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_code,
    input  logic [2:0]                    cmd_level,
    input  logic [2:0]                    cmd_box,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef ARDUINO_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state, next_state;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              baud_last, fifo_empty, push, pop;
`ifdef ARDUINO_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign baud_last  = (baud_cnt == CW'(DIV - 1));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count < (AW+1)'(FIFO_DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign fifo_count = count;
    assign tx_busy    = (state != S_IDLE);

    // Pops happen from IDLE or on the last STOP clock, so queued frames leave with no idle gap.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = S_START;
                end
            end
            S_START: if (baud_last) next_state = S_DATA;
            S_DATA: begin
                if (baud_last && bit_idx == 3'd7) begin
`ifdef ARDUINO_TX_PARITY_EN
                    next_state = S_PARITY;
`else
                    next_state = S_STOP;
`endif
                end
            end
`ifdef ARDUINO_TX_PARITY_EN
            S_PARITY: if (baud_last) next_state = S_STOP;
`endif
            S_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = S_START;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tx_out = 1'b1;
        case (state)
            S_START:  tx_out = 1'b0;
            S_DATA:   tx_out = shift_reg[0];
`ifdef ARDUINO_TX_PARITY_EN
            S_PARITY: tx_out = parity_bit;
`endif
            default:  tx_out = 1'b1;
        endcase
    end

    // Every non-idle state ends on baud_last, so clearing there also clears on each state change.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE || baud_last)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shift_reg <= '0;
            bit_idx   <= '0;
`ifdef ARDUINO_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            shift_reg <= mem[rd_ptr];
            bit_idx   <= '0;
`ifdef ARDUINO_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
        end else if (state == S_DATA && baud_last) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define which entries are valid.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= {cmd_code, cmd_level, cmd_box};
    end

endmodule

// File: tb/tb_arduino_cmd_tx.sv
// Self-checking bench for arduino_cmd_tx; frames are decoded from tx_out and matched against a scoreboard queue.
// Build with ARDUINO_TX_PARITY_EN defined to check the 8E1 variant.
module tb_arduino_cmd_tx;

    localparam int DIV   = 16;
`ifdef ARDUINO_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_code;
    logic [2:0] cmd_level;
    logic [2:0] cmd_box;
    logic       tx_out;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    arduino_cmd_tx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_level  (cmd_level),
        .cmd_box    (cmd_box),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Holds the frame on the inputs until accepted, then scrambles the inputs.
    task automatic push_frame(input logic [7:0] f, output int stalls);
        cmd_code  = f[7:6];
        cmd_level = f[5:3];
        cmd_box   = f[2:0];
        cmd_valid = 1'b1;
        stalls    = 0;
        while (cmd_ready !== 1'b1 && stalls < 500) begin
            tick();
            stalls++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, stalls);
        end else begin
            exp_q.push_back(f);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_code  = ~f[7:6];
        cmd_level = ~f[5:3];
        cmd_box   = ~f[2:0];
    endtask

    // Returns one tick before the next frame slot would begin.
    task automatic rx_frame(input int budget, output int waited);
        logic [7:0] b;
        logic [7:0] expv;
        logic       st, sp;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (tx_out !== 1'b0 && waited < budget);
        checks++;
        if (tx_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_start_timeout: tx_out=%b after %0d cycles, required 0", tx_out, waited);
            return;
        end
        repeat (DIV/2) tick();
        st = tx_out;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) tick();
            b[i] = tx_out;
        end
        expv = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
`ifdef ARDUINO_TX_PARITY_EN
        repeat (DIV) tick();
        checks++;
        if (tx_out !== ^expv) begin
            errors++;
            $display("[TB] FAIL rx_parity: got %b, required %b", tx_out, ^expv);
        end
`endif
        repeat (DIV) tick();
        sp = tx_out;
        repeat (DIV/2 - 1) tick();
        checks++;
        if (st !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_start_bit: got %b, required 0", st);
        end
        checks++;
        if (sp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rx_stop_bit: got %b, required 1", sp);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL rx_unexpected_frame: got %h, scoreboard empty", b);
        end else begin
            expv = exp_q.pop_front();
            if (b !== expv) begin
                errors++;
                $display("[TB] FAIL rx_data: got %h, required %h", b, expv);
            end
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = '0;
        cmd_level = '0;
        cmd_box   = '0;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: tx_out=%b busy=%b ready=%b count=%0d, required 1 0 1 0",
                     tx_out, tx_busy, cmd_ready, fifo_count);
        end
        repeat (3) tick();
        resetn = 1'b1;
        repeat (50) tick();
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: tx_out=%b busy=%b ready=%b count=%0d, required 1 0 1 0",
                     tx_out, tx_busy, cmd_ready, fifo_count);
        end
    endtask

    task automatic test_single_frame();
        int stalls, waited;
        push_frame({2'b00, 3'b011, 3'b101}, stalls);
        checks++;
        if (exp_q.size() != 1 || exp_q[0] !== 8'h1D) begin
            errors++;
            $display("[TB] FAIL frame_packing: size=%0d head=%h, required 1 entry 1d", exp_q.size(), exp_q[0]);
        end
        rx_frame(100, waited);
        checks++;
        if (waited != 1) begin
            errors++;
            $display("[TB] FAIL start_latency: got %0d cycles, required 1", waited);
        end
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_last_stop_clk: got %b, required 1 at clk %0d", tx_busy, SLOTS*DIV);
        end
        tick();
        checks++;
        if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_drop: busy=%b tx_out=%b, required 0 1 at clk %0d", tx_busy, tx_out, SLOTS*DIV+1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frames [6] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h7E};
        fork
            begin
                int stalls;
                for (int i = 0; i < 6; i++) begin
                    if (i == 5) begin
                        checks++;
                        if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
                            errors++;
                            $display("[TB] FAIL full_flags: ready=%b count=%0d, required 0 4", cmd_ready, fifo_count);
                        end
                    end
                    push_frame(frames[i], stalls);
                    if (i == 5) begin
                        checks++;
                        if (stalls < 100) begin
                            errors++;
                            $display("[TB] FAIL full_stall: stalled %0d cycles, required >= 100", stalls);
                        end
                    end
                end
            end
            begin
                int waited;
                for (int i = 0; i < 6; i++) begin
                    rx_frame(400, waited);
                    if (i > 0) begin
                        checks++;
                        if (waited != 1) begin
                            errors++;
                            $display("[TB] FAIL b2b_gap frame %0d: waited %0d cycles, required 1", i, waited);
                        end
                    end
                end
            end
        join
        tick();
        checks++;
        if (tx_busy !== 1'b0 || fifo_count !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: busy=%b count=%0d pending=%0d, required 0 0 0", tx_busy, fifo_count, exp_q.size());
        end
    endtask

    task automatic test_push_pop_same_cycle();
        fork
            begin
                int stalls;
                push_frame(8'h12, stalls);
                push_frame(8'h34, stalls);
                push_frame(8'h56, stalls);
                repeat (SLOTS*DIV - 2) tick();
                checks++;
                if (fifo_count !== 3'd2) begin
                    errors++;
                    $display("[TB] FAIL pp_count_before: got %0d, required 2", fifo_count);
                end
                push_frame(8'h9B, stalls);
                checks++;
                if (fifo_count !== 3'd2) begin
                    errors++;
                    $display("[TB] FAIL pp_count_after: got %0d, required 2", fifo_count);
                end
            end
            begin
                int waited;
                for (int i = 0; i < 4; i++) rx_frame(400, waited);
            end
        join
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_frame();
        int stalls, waited;
        push_frame(8'h05, stalls);
        push_frame(8'h66, stalls);
        push_frame(8'h99, stalls);
        waited = 0;
        while (tx_out !== 1'b0 && waited < 50) begin
            tick();
            waited++;
        end
        repeat (DIV/2 + 4*DIV) tick();
        checks++;
        if (tx_out !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_bit3_line: tx_out=%b busy=%b, required 0 1", tx_out, tx_busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_reset: tx_out=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                     tx_out, tx_busy, fifo_count, cmd_ready);
        end
        exp_q.delete();
        repeat (3) tick();
        resetn = 1'b1;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) waited++;
        end
        checks++;
        if (waited != 0) begin
            errors++;
            $display("[TB] FAIL residual_frame: %0d active cycles after reset, required 0", waited);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_push_pop_same_cycle();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
